issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/riscv_pkg.sv | 19 +
 rtl/issue_scheduler_if.sv | 48 ++++
 rtl/oldest_picker.sv | 22 ++
 rtl/issue_scheduler.sv | 139 +++++++++++++
 tb/tb_issue_scheduler.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants: tag width, scheduler depth default, opcode and issue-port encodings.
// Pure declarations; no timing or flow control of its own.
package riscv_pkg;
  localparam int TAG_W = 6;
  localparam int DEPTH = 8;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_MEM = 1'b1
  } port_e;
endpackage

// File: rtl/issue_scheduler_if.sv
// Decode-to-scheduler-to-execute bundle: allocation, wakeup broadcast, two issue ports, flush.
// master = decode/execute side, slave = scheduler; valid/ready on alloc and both issue ports.
interface issue_scheduler_if #(
  parameter int DEPTH = riscv_pkg::DEPTH,
  parameter int TAG_W = riscv_pkg::TAG_W
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             alloc_valid;
  logic             alloc_ready;
  logic [6:0]       alloc_op;
  logic             alloc_is_mem;
  logic [TAG_W-1:0] alloc_src1_tag;
  logic [TAG_W-1:0] alloc_src2_tag;
  logic             alloc_src1_rdy;
  logic             alloc_src2_rdy;
  logic [TAG_W-1:0] alloc_dst_tag;
  logic             wake_valid;
  logic [TAG_W-1:0] wake_tag;
  logic             alu_iss_valid;
  logic             alu_iss_ready;
  logic [6:0]       alu_iss_op;
  logic [TAG_W-1:0] alu_iss_dst;
  logic [IDX_W-1:0] alu_iss_idx;
  logic             mem_iss_valid;
  logic             mem_iss_ready;
  logic [6:0]       mem_iss_op;
  logic [TAG_W-1:0] mem_iss_dst;
  logic [IDX_W-1:0] mem_iss_idx;
  logic             flush;
  logic [IDX_W:0]   occupancy;

  modport master (
    output alloc_valid, alloc_op, alloc_is_mem, alloc_src1_tag, alloc_src2_tag,
           alloc_src1_rdy, alloc_src2_rdy, alloc_dst_tag, wake_valid, wake_tag,
           alu_iss_ready, mem_iss_ready, flush,
    input  alloc_ready, alu_iss_valid, alu_iss_op, alu_iss_dst, alu_iss_idx,
           mem_iss_valid, mem_iss_op, mem_iss_dst, mem_iss_idx, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_is_mem, alloc_src1_tag, alloc_src2_tag,
           alloc_src1_rdy, alloc_src2_rdy, alloc_dst_tag, wake_valid, wake_tag,
           alu_iss_ready, mem_iss_ready, flush,
    output alloc_ready, alu_iss_valid, alu_iss_op, alu_iss_dst, alu_iss_idx,
           mem_iss_valid, mem_iss_op, mem_iss_dst, mem_iss_idx, occupancy
  );
endinterface

// File: rtl/oldest_picker.sv
// Grants the eligible entry that no other eligible entry is older than; purely combinational.
// No flow control: the caller decides whether the grant is consumed.
module oldest_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0]        elig,
  input  logic [N-1:0][N-1:0] age,   // age[j][i]: entry j was allocated before entry i
  output logic [N-1:0]        grant,
  output logic                valid
);
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = elig[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && elig[j] && age[j][i]) grant[i] = 1'b0;
      end
    end
  end

  assign valid = |elig;
endmodule

// File: rtl/issue_scheduler.sv
// Unified reservation station: allocate at lowest free slot, wake by tag, issue oldest-ready per port.
// Issue outputs are combinational from state; a stalled port keeps its choice until accepted.
module issue_scheduler #(
  parameter int DEPTH = riscv_pkg::DEPTH,
  parameter int TAG_W = riscv_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  issue_scheduler_if.slave bus
);
  import riscv_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    port_e            port;
    logic [6:0]       op;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_rdy;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_rdy;
    logic [TAG_W-1:0] dst;
  } entry_t;

  entry_t                      ent [DEPTH];
  entry_t                      new_ent;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [DEPTH-1:0]            elig_alu, elig_mem, gnt_alu, gnt_mem;
  logic                        pick_alu, pick_mem;
  logic                        lock_alu, lock_mem;
  logic [IDX_W-1:0]            lock_alu_idx, lock_mem_idx, sel_alu_idx, sel_mem_idx, free_idx;
  logic [IDX_W:0]              occ;
  logic                        alloc_fire, alu_fire, mem_fire, wake_hit;

  // Tag 0 is the hardwired zero register: always ready, never a wakeup source.
  function automatic logic src_ready(input logic rdy, input logic [TAG_W-1:0] tag,
                                     input logic wv, input logic [TAG_W-1:0] wt);
    return rdy || (tag == '0) || (wv && (wt != '0) && (wt == tag));
  endfunction

  assign wake_hit = bus.wake_valid && (bus.wake_tag != '0);
  assign occ      = (IDX_W+1)'($countones(valid));

  always_comb begin
    elig_alu = '0;
    elig_mem = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig_alu[i] = valid[i] && ent[i].src1_rdy && ent[i].src2_rdy && (ent[i].port == PORT_ALU);
      elig_mem[i] = valid[i] && ent[i].src1_rdy && ent[i].src2_rdy && (ent[i].port == PORT_MEM);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  oldest_picker #(.N(DEPTH)) u_pick_alu (.elig(elig_alu), .age(age), .grant(gnt_alu), .valid(pick_alu));
  oldest_picker #(.N(DEPTH)) u_pick_mem (.elig(elig_mem), .age(age), .grant(gnt_mem), .valid(pick_mem));

  always_comb begin
    sel_alu_idx = lock_alu_idx;
    sel_mem_idx = lock_mem_idx;
    if (!lock_alu) begin
      sel_alu_idx = '0;
      for (int i = 0; i < DEPTH; i++) if (gnt_alu[i]) sel_alu_idx = IDX_W'(i);
    end
    if (!lock_mem) begin
      sel_mem_idx = '0;
      for (int i = 0; i < DEPTH; i++) if (gnt_mem[i]) sel_mem_idx = IDX_W'(i);
    end
  end

  always_comb begin
    new_ent.port     = bus.alloc_is_mem ? PORT_MEM : PORT_ALU;
    new_ent.op       = bus.alloc_op;
    new_ent.src1_tag = bus.alloc_src1_tag;
    new_ent.src2_tag = bus.alloc_src2_tag;
    new_ent.src1_rdy = src_ready(bus.alloc_src1_rdy, bus.alloc_src1_tag, bus.wake_valid, bus.wake_tag);
    new_ent.src2_rdy = src_ready(bus.alloc_src2_rdy, bus.alloc_src2_tag, bus.wake_valid, bus.wake_tag);
    new_ent.dst      = bus.alloc_dst_tag;
  end

  assign bus.alloc_ready   = occ < (IDX_W+1)'(DEPTH);
  assign bus.occupancy     = occ;
  assign alloc_fire        = bus.alloc_valid && bus.alloc_ready && !bus.flush;

  assign bus.alu_iss_valid = !bus.flush && (lock_alu || pick_alu);
  assign bus.alu_iss_op    = bus.alu_iss_valid ? ent[sel_alu_idx].op  : '0;
  assign bus.alu_iss_dst   = bus.alu_iss_valid ? ent[sel_alu_idx].dst : '0;
  assign bus.alu_iss_idx   = bus.alu_iss_valid ? sel_alu_idx : '0;
  assign alu_fire          = bus.alu_iss_valid && bus.alu_iss_ready;

  assign bus.mem_iss_valid = !bus.flush && (lock_mem || pick_mem);
  assign bus.mem_iss_op    = bus.mem_iss_valid ? ent[sel_mem_idx].op  : '0;
  assign bus.mem_iss_dst   = bus.mem_iss_valid ? ent[sel_mem_idx].dst : '0;
  assign bus.mem_iss_idx   = bus.mem_iss_valid ? sel_mem_idx : '0;
  assign mem_fire          = bus.mem_iss_valid && bus.mem_iss_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid        <= '0;
      age          <= '0;
      lock_alu     <= 1'b0;
      lock_mem     <= 1'b0;
      lock_alu_idx <= '0;
      lock_mem_idx <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (bus.flush) begin
      valid    <= '0;
      age      <= '0;
      lock_alu <= 1'b0;
      lock_mem <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && wake_hit && ent[i].src1_tag == bus.wake_tag) ent[i].src1_rdy <= 1'b1;
        if (valid[i] && wake_hit && ent[i].src2_tag == bus.wake_tag) ent[i].src2_rdy <= 1'b1;
      end
      if (alu_fire) valid[sel_alu_idx] <= 1'b0;
      if (mem_fire) valid[sel_mem_idx] <= 1'b0;
      lock_alu     <= bus.alu_iss_valid && !bus.alu_iss_ready;
      lock_mem     <= bus.mem_iss_valid && !bus.mem_iss_ready;
      lock_alu_idx <= sel_alu_idx;
      lock_mem_idx <= sel_mem_idx;
      // The new entry is younger than everything currently held.
      if (alloc_fire) begin
        valid[free_idx] <= 1'b1;
        ent[free_idx]   <= new_ent;
        for (int j = 0; j < DEPTH; j++) begin
          age[free_idx][j] <= 1'b0;
          age[j][free_idx] <= valid[j];
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed scenarios followed by random traffic, all checked against an in-order queue model.
module tb_issue_scheduler;
  import riscv_pkg::*;

  typedef struct {
    int               idx;
    bit               mem;
    logic [6:0]       op;
    logic [TAG_W-1:0] dst, t1, t2;
    bit               r1, r2;
  } m_ent_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  m_ent_t q[$];          // model entries, oldest first
  bit     lk_alu, lk_mem;
  int     lk_alu_idx, lk_mem_idx;

  issue_scheduler_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  issue_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alloc_valid = 0; bus.alloc_op = '0; bus.alloc_is_mem = 0;
    bus.alloc_src1_tag = '0; bus.alloc_src1_rdy = 0;
    bus.alloc_src2_tag = '0; bus.alloc_src2_rdy = 0;
    bus.alloc_dst_tag = '0; bus.wake_valid = 0; bus.wake_tag = '0;
    bus.alu_iss_ready = 1; bus.mem_iss_ready = 1; bus.flush = 0;
  endtask

  task automatic alloc(input bit mem, input logic [6:0] op, input logic [TAG_W-1:0] t1, input bit r1,
                       input logic [TAG_W-1:0] t2, input bit r2, input logic [TAG_W-1:0] dst);
    bus.alloc_valid = 1; bus.alloc_is_mem = mem; bus.alloc_op = op;
    bus.alloc_src1_tag = t1; bus.alloc_src1_rdy = r1;
    bus.alloc_src2_tag = t2; bus.alloc_src2_rdy = r2; bus.alloc_dst_tag = dst;
  endtask

  task automatic wake(input logic [TAG_W-1:0] t);
    bus.wake_valid = 1; bus.wake_tag = t;
  endtask

  function automatic int find_pick(input bit mem, input bit lk, input int lk_idx);
    if (lk) begin
      for (int k = 0; k < q.size(); k++) if (q[k].idx == lk_idx) return k;
      return -1;
    end
    for (int k = 0; k < q.size(); k++) if (q[k].mem == mem && q[k].r1 && q[k].r2) return k;
    return -1;
  endfunction

  function automatic bit src_rdy(input bit r, input logic [TAG_W-1:0] t);
    return r || (t == 0) || (bus.wake_valid && bus.wake_tag != 0 && bus.wake_tag == t);
  endfunction

  // Compare outputs with the model for the current cycle, then advance the model past the edge.
  task automatic cyc();
    int     pa, pm, nidx, aid, mid;
    bit     used [DEPTH];
    m_ent_t e;
    #1;
    pa = bus.flush ? -1 : find_pick(1'b0, lk_alu, lk_alu_idx);
    pm = bus.flush ? -1 : find_pick(1'b1, lk_mem, lk_mem_idx);
    chk("occupancy", bus.occupancy, q.size());
    chk("alloc_ready", bus.alloc_ready, q.size() < DEPTH);
    chk("alu_iss_valid", bus.alu_iss_valid, pa >= 0);
    chk("mem_iss_valid", bus.mem_iss_valid, pm >= 0);
    if (pa >= 0) begin
      chk("alu_iss_idx", bus.alu_iss_idx, q[pa].idx);
      chk("alu_iss_dst", bus.alu_iss_dst, q[pa].dst);
      chk("alu_iss_op", bus.alu_iss_op, q[pa].op);
    end
    if (pm >= 0) begin
      chk("mem_iss_idx", bus.mem_iss_idx, q[pm].idx);
      chk("mem_iss_dst", bus.mem_iss_dst, q[pm].dst);
      chk("mem_iss_op", bus.mem_iss_op, q[pm].op);
    end
    if (bus.flush) begin
      q.delete();
      lk_alu = 0;
      lk_mem = 0;
    end else begin
      nidx = -1;
      if (bus.alloc_valid && q.size() < DEPTH) begin
        foreach (used[i]) used[i] = 0;
        foreach (q[k]) used[q[k].idx] = 1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!used[i]) nidx = i;
        e.idx = nidx; e.mem = bus.alloc_is_mem; e.op = bus.alloc_op; e.dst = bus.alloc_dst_tag;
        e.t1 = bus.alloc_src1_tag; e.t2 = bus.alloc_src2_tag;
        e.r1 = src_rdy(bus.alloc_src1_rdy, bus.alloc_src1_tag);
        e.r2 = src_rdy(bus.alloc_src2_rdy, bus.alloc_src2_tag);
      end
      aid = (pa >= 0 && bus.alu_iss_ready) ? q[pa].idx : -1;
      mid = (pm >= 0 && bus.mem_iss_ready) ? q[pm].idx : -1;
      lk_alu = (pa >= 0) && !bus.alu_iss_ready;
      lk_mem = (pm >= 0) && !bus.mem_iss_ready;
      if (pa >= 0) lk_alu_idx = q[pa].idx;
      if (pm >= 0) lk_mem_idx = q[pm].idx;
      if (bus.wake_valid && bus.wake_tag != 0) begin
        foreach (q[k]) begin
          if (q[k].t1 == bus.wake_tag) q[k].r1 = 1;
          if (q[k].t2 == bus.wake_tag) q[k].r2 = 1;
        end
      end
      for (int k = q.size() - 1; k >= 0; k--) if (q[k].idx == aid || q[k].idx == mid) q.delete(k);
      if (nidx >= 0) q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    rstn = 0;
    q.delete();
    lk_alu = 0;
    lk_mem = 0;
    #1;
    chk("rst_occupancy", bus.occupancy, 0);
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_alu_valid", bus.alu_iss_valid, 0);
    chk("rst_mem_valid", bus.mem_iss_valid, 0);
    chk("rst_alu_fields", {bus.alu_iss_op, bus.alu_iss_dst, bus.alu_iss_idx}, 0);
    chk("rst_mem_fields", {bus.mem_iss_op, bus.mem_iss_dst, bus.mem_iss_idx}, 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1;
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset();

    // Single ready ALU op issues the cycle after allocation from slot 0.
    alloc(0, OP_R, 5, 1, 6, 1, 10);
    cyc();
    #1;
    chk("t1_alu_valid", bus.alu_iss_valid, 1);
    chk("t1_alu_idx", bus.alu_iss_idx, 0);
    chk("t1_alu_dst", bus.alu_iss_dst, 10);
    cyc();

    // Younger ready op overtakes older blocked one; older issues after its wakeup.
    alloc(0, OP_R, 9, 0, 3, 1, 20);
    cyc();
    alloc(0, OP_I, 1, 1, 2, 1, 21);
    cyc();
    #1;
    chk("t2_young_first", bus.alu_iss_dst, 21);
    cyc();
    wake(9);
    #1;
    chk("t2_not_yet", bus.alu_iss_valid, 0);
    cyc();
    #1;
    chk("t2_old_after_wake", bus.alu_iss_dst, 20);
    cyc();

    // Fill to capacity, then drain; no slot reuse in the first issuing cycle.
    for (int i = 0; i < DEPTH; i++) begin
      alloc(0, OP_R, 7, 0, 7, 0, TAG_W'(i + 1));
      cyc();
    end
    #1;
    chk("t3_full_ready", bus.alloc_ready, 0);
    chk("t3_full_occ", bus.occupancy, DEPTH);
    wake(7);
    cyc();
    alloc(0, OP_R, 1, 1, 1, 1, 60);
    #1;
    chk("t3_no_same_cycle", bus.alloc_ready, 0);
    cyc();
    #1;
    chk("t3_ready_again", bus.alloc_ready, 1);
    chk("t3_occ_after", bus.occupancy, DEPTH - 1);
    for (int i = 0; i < DEPTH + 2; i++) cyc();

    // Stalled port keeps its selection while an older entry becomes ready.
    alloc(0, OP_R, 11, 0, 12, 1, 30);
    cyc();
    alloc(0, OP_R, 1, 1, 2, 1, 31);
    bus.alu_iss_ready = 0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.alu_iss_ready = 0;
      if (i == 0) wake(11);
      #1;
      chk("t4_locked_idx", bus.alu_iss_idx, 1);
      cyc();
    end
    #1;
    chk("t4_accept_idx", bus.alu_iss_idx, 1);
    cyc();
    #1;
    chk("t4_older_next", bus.alu_iss_dst, 30);
    cyc();

    // Both ports issue in the same cycle.
    alloc(1, OP_LOAD, 1, 1, 0, 0, 40);
    cyc();
    alloc(0, OP_R, 2, 1, 3, 1, 41);
    bus.mem_iss_ready = 0;
    cyc();
    #1;
    chk("t5_both_valid", {bus.alu_iss_valid, bus.mem_iss_valid}, 2'b11);
    chk("t5_occ_before", bus.occupancy, 2);
    cyc();
    #1;
    chk("t5_occ_after", bus.occupancy, 0);

    // Flush with five held entries, then reset while an issue is being accepted.
    for (int i = 0; i < 5; i++) begin
      alloc(i[0], i[0] ? OP_STORE : OP_R, 13, 0, 14, 0, TAG_W'(50 + i));
      cyc();
    end
    #1;
    chk("t6_occ5", bus.occupancy, 5);
    bus.flush = 1;
    alloc(0, OP_R, 1, 1, 1, 1, 55);
    #1;
    chk("t6_flush_no_issue", {bus.alu_iss_valid, bus.mem_iss_valid}, 0);
    cyc();
    #1;
    chk("t6_occ_flushed", bus.occupancy, 0);
    alloc(0, OP_R, 1, 1, 1, 1, 56);
    cyc();
    #1;
    chk("t6_pending_issue", bus.alu_iss_valid, 1);
    do_reset();
    cyc();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 9) < 3)
          alloc(1, $urandom_range(0, 1) ? OP_LOAD : OP_STORE, TAG_W'($urandom_range(0, 7)),
                $urandom_range(0, 9) < 3, TAG_W'($urandom_range(0, 7)), $urandom_range(0, 9) < 3,
                TAG_W'($urandom));
        else
          alloc(0, $urandom_range(0, 1) ? OP_R : OP_BRANCH, TAG_W'($urandom_range(0, 7)),
                $urandom_range(0, 9) < 3, TAG_W'($urandom_range(0, 7)), $urandom_range(0, 9) < 3,
                TAG_W'($urandom));
      end
      if ($urandom_range(0, 1) == 1) wake(TAG_W'($urandom_range(0, 7)));
      bus.alu_iss_ready = $urandom_range(0, 9) < 7;
      bus.mem_iss_ready = $urandom_range(0, 9) < 7;
      bus.flush = ($urandom_range(0, 63) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
